// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one latency-LAT registered ALU between two requesters
module alu_arbiter #(
  parameter int LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res,
  output logic       flag,
  output logic       err,
  output logic       busy,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_s,
  input  logic       alu_flag
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic last_gnt, owner, bad, gnt, sel;
  logic [2:0] op_sel;
  logic [7:0] cnt;
  always_comb begin
    gnt = state == IDLE && (req0 || req1);
    sel = (req0 && req1) ? ~last_gnt : req1;
    op_sel = sel ? op1 : op0;
    state_nx = state == IDLE ? (gnt ? WAIT : IDLE) :
               state == WAIT ? ((bad || cnt == 8'(LAT)) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // illegal opcodes still pass through WAIT for one edge so done lands at N+1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_gnt <= 1'b1;
      owner <= 1'b0;
      bad <= 1'b0;
      cnt <= '0;
      res <= '0;
      flag <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
    end else begin
      if (gnt) begin
        owner <= sel;
        last_gnt <= sel;
        bad <= op_sel > 3'd4;
        cnt <= '0;
        if (op_sel <= 3'd4) begin
          alu_a <= sel ? a1 : a0;
          alu_b <= sel ? b1 : b0;
          alu_op <= op_sel;
        end
      end
      if (state == WAIT) begin
        cnt <= cnt + 8'd1;
        if (bad) begin
          res <= '0;
          flag <= 1'b0;
        end else if (cnt == 8'(LAT)) begin
          res <= alu_s;
          flag <= alu_flag;
        end
      end
    end
  assign done0 = state == DONE && !owner;
  assign done1 = state == DONE && owner;
  assign err = state == DONE && bad;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench with a transaction-level model of arbitration and timing
module tb_alu_arbiter;
  localparam int LAT = 2;
  logic clk = 0, rst = 1;
  logic req0 = 0, req1 = 0;
  logic [2:0] op0 = 0, op1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic done0, done1, flag, err, busy, alu_flag = 0;
  logic [7:0] res, alu_a, alu_b, alu_s = 0;
  logic [2:0] alu_op;
  logic [8:0] s9;
  int checks = 0, errors = 0;

  alu_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .done0(done0), .done1(done1),
    .res(res), .flag(flag), .err(err), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_s(alu_s), .alu_flag(alu_flag)
  );

  always #5 clk = ~clk;

  // external ALU: one register stage after the arbiter's operand register
  always_comb s9 = alu_op == 3'd1 ? {1'b0, alu_a} - {1'b0, alu_b} : {1'b0, alu_a} + {1'b0, alu_b};
  always_ff @(posedge clk) begin
    alu_s <= alu_op <= 3'd1 ? s9[7:0] : alu_op == 3'd2 ? alu_a & alu_b :
             alu_op == 3'd3 ? alu_a | alu_b : alu_a ^ alu_b;
    alu_flag <= alu_op <= 3'd1 ? s9[8] : 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_alu(input int op, input int a, input int b, output int r, output bit f);
    f = 0;
    case (op)
      0: begin r = (a + b) % 256; f = (a + b) > 255; end
      1: begin r = (a - b + 256) % 256; f = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      default: r = 0;
    endcase
  endfunction

  // model: edge index of the grant and of the completion, plus expected registers
  int ec = 0, m_gnt = -100, m_cmp = -100, p_res = 0;
  bit m_last = 1, m_own = 0, m_ill = 0, p_flag = 0, e_flag = 0;
  logic [7:0] e_res = 0, e_a = 0, e_b = 0;
  logic [2:0] e_op = 0;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_gnt = -100; m_cmp = -100; m_last = 1; m_own = 0; m_ill = 0;
      e_res = 0; e_flag = 0; e_a = 0; e_b = 0; e_op = 0;
    end else begin
      ec++;
      if (ec == m_cmp) begin e_res = 8'(p_res); e_flag = p_flag; end
      if (ec >= m_cmp + 2 && (req0 || req1)) begin
        int op, a, b;
        m_own = (req0 && req1) ? !m_last : req1;
        m_last = m_own;
        op = m_own ? int'(op1) : int'(op0);
        a = m_own ? int'(a1) : int'(a0);
        b = m_own ? int'(b1) : int'(b0);
        m_ill = op > 4;
        m_gnt = ec;
        m_cmp = ec + (m_ill ? 1 : LAT + 1);
        if (!m_ill) begin e_a = 8'(a); e_b = 8'(b); e_op = 3'(op); end
        model_alu(op, a, b, p_res, p_flag);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy", busy, ec >= m_gnt && ec <= m_cmp);
    chk("done0", done0, ec == m_cmp && !m_own);
    chk("done1", done1, ec == m_cmp && m_own);
    chk("err", err, ec == m_cmp && m_ill);
    chk("res", res, e_res);
    chk("flag", flag, e_flag);
    chk("alu_a", alu_a, e_a);
    chk("alu_b", alu_b, e_b);
    chk("alu_op", alu_op, e_op);
  end

  task automatic wait_grant();
    int n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 20);
    chk("grant_timeout", n < 20, 1);
  endtask

  task automatic wait_done(input int which, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(which == 0 ? done0 : which == 1 ? done1 : (done0 || done1)) && n < 30);
    chk("done_timeout", n < 30, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res", res, 0);
    rst = 0;
    req0 = 1; a0 = 8'hF0; b0 = 8'h20; op0 = 3'd0;
    wait_grant();
    wait_done(0, n);
    chk("add_latency", n, 3);
    chk("add_res", res, 8'h10);
    chk("add_flag", flag, 1);
    chk("add_err", err, 0);
    req0 = 0;
    @(negedge clk); #1 rst = 1;
    req0 = 1; op0 = 3'd1; a0 = 8'h10; b0 = 8'h01;
    req1 = 1; op1 = 3'd1; a1 = 8'h05; b1 = 8'h07;
    @(negedge clk); rst = 0;
    wait_grant();
    wait_done(0, n);
    chk("tie_first_done1", done1, 0);
    chk("tie_first_res", res, 8'h0F);
    req0 = 0;
    wait_done(1, n);
    chk("tie_second_gap", n, 5);
    chk("tie_second_done0", done0, 0);
    chk("sub_res", res, 8'hFE);
    chk("sub_flag", flag, 1);
    req1 = 0;
    req1 = 1; op1 = 3'd6; a1 = 8'h99; b1 = 8'h66;
    wait_grant();
    wait_done(1, n);
    chk("ill_latency", n, 1);
    chk("ill_err", err, 1);
    chk("ill_res", res, 0);
    chk("ill_alu_a", alu_a, 8'h05);
    chk("ill_alu_op", alu_op, 3'd1);
    req1 = 0;
    @(negedge clk); #1 rst = 1;
    req0 = 1; op0 = 3'd2; a0 = 8'h3C; b0 = 8'h0F;
    req1 = 1; op1 = 3'd4; a1 = 8'h55; b1 = 8'hFF;
    @(negedge clk); rst = 0;
    wait_grant();
    for (int i = 0; i < 4; i++) begin
      wait_done(2, n);
      chk("rr_gap", n, i == 0 ? 3 : 5);
      chk("rr_owner", done1, i % 2);
      chk("rr_res", res, i % 2 ? 8'hAA : 8'h0C);
    end
    req0 = 0; req1 = 0;
    req0 = 1; op0 = 3'd0; a0 = 8'h01; b0 = 8'h02;
    req1 = 1; op1 = 3'd3; a1 = 8'h50; b1 = 8'h0A;
    wait_grant();
    @(negedge clk); #1 rst = 1; req0 = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done0", done0, 0);
    chk("abort_err", err, 0);
    chk("abort_res", res, 0);
    chk("abort_alu_a", alu_a, 0);
    rst = 0;
    @(negedge clk);
    chk("after_rst_busy", busy, 1);
    chk("after_rst_alu_a", alu_a, 8'h50);
    chk("after_rst_alu_op", alu_op, 3'd3);
    wait_done(1, n);
    chk("after_rst_latency", n, 3);
    chk("after_rst_res", res, 8'h5A);
    req1 = 0;
    req0 = 1; op0 = 3'd2; a0 = 8'hCC; b0 = 8'hAA;
    wait_grant();
    @(negedge clk); req0 = 0; a0 = 8'h00; b0 = 8'h00;
    wait_done(0, n);
    chk("drop_latency", n, 2);
    chk("drop_res", res, 8'h88);
    chk("drop_flag", flag, 0);
    repeat (4) @(negedge clk);
    chk("hold_res", res, 8'h88);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
